inst_fetch_queue: RTL and testbench

- Consumer end of the fetch interface. Accepts instruction/PC pairs from the fetch stage, buffers them in a small FIFO, and presents them to decode with a valid/ready handshake.
- Drives the pause input of the fetch stage back-pressure.
- Discards all buffered entries on a branch/jump redirect. The redirect is the same event that write-enables the fetch PC.

---
 rtl/inst_fetch_queue_if.sv | 31 +++
 rtl/inst_fetch_queue.sv | 97 +++++++++
 tb/tb_inst_fetch_queue.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_queue_if
//  Brief    : Fetch-to-decode handshake bundle for the instruction fetch queue.
//  Revision : 1.0  initial release
// ============================================================================
interface inst_fetch_queue_if #(
    parameter int AW = 2
);
    logic          i_IFQ_valid;
    logic [31:0]   i_IFQ_inst;
    logic [31:0]   i_IFQ_PC;
    logic          i_IFQ_flush;
    logic          i_IFQ_ready;
    logic          o_IFQ_pause;
    logic          o_IFQ_valid;
    logic [31:0]   o_IFQ_inst;
    logic [31:0]   o_IFQ_PC;
    logic [AW:0]   o_IFQ_count;

    modport slave (
        input  i_IFQ_valid, i_IFQ_inst, i_IFQ_PC, i_IFQ_flush, i_IFQ_ready,
        output o_IFQ_pause, o_IFQ_valid, o_IFQ_inst, o_IFQ_PC, o_IFQ_count
    );

    modport master (
        output i_IFQ_valid, i_IFQ_inst, i_IFQ_PC, i_IFQ_flush, i_IFQ_ready,
        input  o_IFQ_pause, o_IFQ_valid, o_IFQ_inst, o_IFQ_PC, o_IFQ_count
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_queue
//  Brief    : Small FIFO between fetch and decode with back-pressure and
//             redirect flush. Optional same-cycle bypass: IFQ_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  wire               clk,
    input  wire               rst,
    inst_fetch_queue_if.slave ifq
);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    generate
        if ((DEPTH < 2) || (DEPTH != (1 << AW))) begin : g_param_check
            $error("inst_fetch_queue: DEPTH must be a power of 2 >= 2 and equal 2**AW");
        end
    endgenerate

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rp;
    logic [AW-1:0] r_wp;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_bypass_take;
    logic w_enq;
    logic w_deq;

    // Status comes only from the registered count, so pause has no input path.
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

`ifdef IFQ_BYPASS_EN
    assign w_bypass = w_empty & ifq.i_IFQ_valid & ~ifq.i_IFQ_flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed pair that decode takes immediately is never written.
    assign w_bypass_take = w_bypass & ifq.i_IFQ_ready;
    assign w_enq = ifq.i_IFQ_valid & ~w_full & ~ifq.i_IFQ_flush & ~w_bypass_take;
    assign w_deq = ~w_empty & ifq.i_IFQ_ready & ~ifq.i_IFQ_flush;

    always_ff @(posedge clk) begin
        if (rst || ifq.i_IFQ_flush) begin
            r_rp    <= '0;
            r_wp    <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_deq) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wp] <= {ifq.i_IFQ_inst, ifq.i_IFQ_PC};
        end
    end

    always_comb begin
        ifq.o_IFQ_valid = 1'b0;
        ifq.o_IFQ_inst  = NOP_INST;
        ifq.o_IFQ_PC    = '0;
        if (!w_empty) begin
            ifq.o_IFQ_valid = 1'b1;
            ifq.o_IFQ_inst  = r_mem[r_rp][63:32];
            ifq.o_IFQ_PC    = r_mem[r_rp][31:0];
        end else if (w_bypass) begin
            ifq.o_IFQ_valid = 1'b1;
            ifq.o_IFQ_inst  = ifq.i_IFQ_inst;
            ifq.o_IFQ_PC    = ifq.i_IFQ_PC;
        end
    end

    assign ifq.o_IFQ_pause = w_full;
    assign ifq.o_IFQ_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_queue
//  Brief    : Scoreboard bench for inst_fetch_queue; directed plan then random.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch_queue;
    localparam int          DEPTH = 4;
    localparam int          AW    = 2;
    localparam logic [31:0] NOP   = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    inst_fetch_queue_if #(.AW(AW)) ifq ();

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NOP_INST (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ifq (ifq)
    );

    always #5 clk = ~clk;

    // Expected decode-side stream: front is what the head must show.
    logic [63:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the acceptance decision uses the pre-edge occupancy.
    task automatic cycle(input bit r, input bit v, input logic [31:0] ins,
                         input logic [31:0] pc, input bit rdy, input bit fl);
        bit take_now;
        bit push;
        @(negedge clk);
        rst             = r;
        ifq.i_IFQ_valid = v;
        ifq.i_IFQ_inst  = ins;
        ifq.i_IFQ_PC    = pc;
        ifq.i_IFQ_ready = rdy;
        ifq.i_IFQ_flush = fl;
        take_now = c_BYP && (sb.size() == 0) && v && !fl && rdy;
        push     = !r && v && !fl && (sb.size() < DEPTH) && !take_now;
        @(posedge clk);
        if (r || fl) sb.delete();
        else if (push) sb.push_back({ins, pc});
    endtask

    // Monitor: compares mid-cycle and retires the head when decode takes it.
    initial begin
        logic [63:0] exp_head;
        bit          exp_valid;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            chk("count", 32'(ifq.o_IFQ_count), 32'(sb.size()));
            chk("pause", 32'(ifq.o_IFQ_pause), 32'(sb.size() == DEPTH));
            exp_valid = 1'b0;
            exp_head  = {NOP, 32'h0};
            if (sb.size() != 0) begin
                exp_valid = 1'b1;
                exp_head  = sb[0];
            end else if (c_BYP && ifq.i_IFQ_valid && !ifq.i_IFQ_flush) begin
                exp_valid = 1'b1;
                exp_head  = {ifq.i_IFQ_inst, ifq.i_IFQ_PC};
            end
            chk("valid", 32'(ifq.o_IFQ_valid), 32'(exp_valid));
            chk("inst",  ifq.o_IFQ_inst, exp_head[63:32]);
            chk("pc",    ifq.o_IFQ_PC,   exp_head[31:0]);
            if (sb.size() != 0 && ifq.i_IFQ_ready && !ifq.i_IFQ_flush && !rst)
                void'(sb.pop_front());
        end
    end

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 32'h0, 1, 0);
    endtask

    initial begin
        int rdy_pct;
        ifq.i_IFQ_valid = 1'b0;
        ifq.i_IFQ_inst  = 32'h0;
        ifq.i_IFQ_PC    = 32'h0;
        ifq.i_IFQ_ready = 1'b0;
        ifq.i_IFQ_flush = 1'b0;

        cycle(1, 0, 32'h0, 32'h0, 0, 0);
        cycle(1, 0, 32'h0, 32'h0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);

        // Ordered pass-through
        cycle(0, 1, 32'h2008_0001, 32'h00, 0, 0);
        cycle(0, 1, 32'h2009_0002, 32'h04, 0, 0);
        cycle(0, 1, 32'h0109_5020, 32'h08, 0, 0);
        drain(4);

        // Saturate, then release one slot
        for (int i = 0; i < 6; i++) cycle(0, 1, $urandom, 32'h100 + 32'(4*i), 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 1, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        drain(5);

        // Simultaneous enqueue/dequeue at count 2
        cycle(0, 1, 32'hA000_0001, 32'h200, 0, 0);
        cycle(0, 1, 32'hA000_0002, 32'h204, 0, 0);
        cycle(0, 1, 32'hA000_0003, 32'h208, 1, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        drain(4);

        // Flush mid-stream with valid and ready also high
        for (int i = 0; i < 3; i++) cycle(0, 1, $urandom, 32'h300 + 32'(4*i), 0, 0);
        cycle(0, 1, 32'hDEAD_BEEF, 32'h30C, 1, 1);
        cycle(0, 1, 32'hB000_0040, 32'h40, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);
        drain(3);

        // Wrap-around with paired traffic
        for (int i = 0; i < 10; i++) cycle(0, 1, 32'hC000_0000 + 32'(i), 32'(4*i), 1, 0);
        drain(3);

        // Randomised traffic in phases of varying decode pressure
        rdy_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) rdy_pct = $urandom_range(0, 2) * 45 + 5;
            cycle(($urandom_range(0, 399) == 0),
                  ($urandom_range(0, 99) < 75),
                  $urandom, $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 99) < rdy_pct),
                  ($urandom_range(0, 29) == 0));
        end
        drain(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
